time_entry_loader: RTL and testbench
====================================

Name: time_entry_loader

Overview:
- Keypad-side writer for the microwave countdown timer chain.
- Collects decimal key presses into a four-digit MM:SS value, calculator style.
- Validates the value, then drives the parallel-load bus and the active-low load strobe of the four mod-10/mod-6 down-counters.
- Issues a one-cycle start pulse to the controller and holds off new entry until the countdown finishes.

Parameters:
- SEC_TENS_MAX, 5, largest legal seconds-tens digit; START is rejected if sec_tens exceeds it.
- MAX_DIGITS, 4, number of digits accepted before further digit keys are ignored.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clear  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe from the keypad scanner; every cycle high counts as one press.
- key_code  in  4  4'h0-4'h9 digit; 4'hA CANCEL; 4'hB START; 4'hC-4'hF ignored.
- running  in  1  high while the countdown chain is enabled (counter en).
- sec_units  out  4  entered seconds units; drives counter input_signal.
- sec_tens  out  4  entered seconds tens.
- min_units  out  4  entered minutes units.
- min_tens  out  4  entered minutes tens.
- load  out  1  active-low load strobe to all four counters.
- start  out  1  one-cycle pulse to the controller to enable counting.
- digit_count  out  3  digits entered so far, 0..MAX_DIGITS.
- entry_error  out  1  high after a rejected START.
- busy  out  1  high in LOAD, GO and RUN.

Behaviour:
- Reset (clear low, async): state IDLE; all digits 0; digit_count 0; load 1; start 0; entry_error 0; busy 0; running_q 0.
- All outputs are registered and update one cycle after the causing key_valid edge.
- Digit key in IDLE/ENTRY with digit_count < MAX_DIGITS:
  - min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key.
  - digit_count+1.
  - entry_error<=0.
  - state ENTRY.
- Digit key with digit_count == MAX_DIGITS: ignored; no shift, count stays 4, entry_error unchanged.
- CANCEL in IDLE/ENTRY: digits 0, count 0, entry_error 0, state IDLE.
- START in IDLE (count 0): ignored.
- START in ENTRY:
  - If sec_tens > SEC_TENS_MAX: entry_error<=1; digits kept; stay ENTRY.
  - Otherwise: state LOAD.
- A digit or CANCEL accepted after a rejected START clears entry_error.
- LOAD: load=0 for exactly one cycle; digit outputs stable; next state GO.
- GO: start=1 for exactly one cycle; next state RUN.
- RUN:
  - running_q registers running.
  - On running_q=1 and running=0 (falling edge): digits 0, count 0, state IDLE.
  - If running never rises, the block stays in RUN until reset. The controller guarantees running rises.
- busy=1 in LOAD/GO/RUN. All key_valid in these states is ignored, including CANCEL; stopping is the controller's job.
- Digits always hold 0..9 because codes above 9 never shift in. Minutes are unrestricted (up to 99).
- load and start are never asserted in the same cycle.
- load is high in every state except LOAD.
- Reset mid-operation (any state, including LOAD with load low): outputs return to reset values immediately, asynchronously.
- Undefined key codes: no state, digit, count or error change.

Test Plan:
- Reset, then keys 1,3,0 (one cycle each, gaps between) -> min_units=1, sec_tens=3, sec_units=0, min_tens=0, digit_count=3, load=1.
- Keys 9,9,5,9,7 -> digits 9,9,5,9; fifth key ignored; digit_count=4.
- Keys 1,7,0 then START -> entry_error=1, load stays 1, state ENTRY. Then CANCEL -> digits 0, count 0, error 0.
- Keys 2,0,0 then START -> next cycle load=0 with min_units=2, sec_tens=0, sec_units=0; following cycle start=1 and load=1; busy=1. Digit key 5 during RUN is ignored. Raise running for 10 cycles, drop it -> one cycle later state IDLE, digits 0, busy=0.
- START with digit_count=0 -> no load, no start, no error. key_code 4'hE strobe -> no change.
- Assert clear during LOAD -> load returns to 1 immediately, start stays 0, all digits 0, state IDLE.

Source files
------------

// File: rtl/time_entry_loader.sv
// ---------------------------------------------------------------------------
// time_entry_loader
//   Keypad-side writer for the microwave countdown timer chain. Digit keys
//   shift into a four-digit MM:SS value calculator style (newest digit enters
//   at seconds units). START validates the seconds-tens digit, then pulses the
//   active-low parallel-load strobe of the four down-counters for one cycle,
//   follows with a one-cycle start pulse to the controller, and locks out the
//   keypad until the countdown chain reports completion (running falls).
//
// Ports
//   clk          system clock, all state changes on posedge
//   clear        asynchronous active-low reset
//   key_valid    one-cycle key strobe from the keypad scanner
//   key_code     0-9 digit, A cancel, B start, C-F ignored
//   running      countdown chain enable, high while counting
//   sec_units    entered seconds units (counter parallel-load data)
//   sec_tens     entered seconds tens
//   min_units    entered minutes units
//   min_tens     entered minutes tens
//   load         active-low load strobe to all four counters
//   start        one-cycle pulse to the controller to enable counting
//   digit_count  digits entered so far, 0..MAX_DIGITS
//   entry_error  high after a rejected START
//   busy         high while loading, starting or running
// ---------------------------------------------------------------------------
module time_entry_loader #(
    parameter int SEC_TENS_MAX = 5,
    parameter int MAX_DIGITS   = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       running,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       load,
    output logic       start,
    output logic [2:0] digit_count,
    output logic       entry_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GO    = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    state_t state_r;
    logic   running_q_r;

    logic   key_digit_s;
    logic   key_cancel_s;
    logic   key_start_s;
    logic   room_s;
    logic   tens_bad_s;

    // Key decode; codes C-F match none of these and so change nothing.
    assign key_digit_s  = key_valid && (key_code <= 4'd9);
    assign key_cancel_s = key_valid && (key_code == 4'hA);
    assign key_start_s  = key_valid && (key_code == 4'hB);
    assign room_s       = (digit_count < 3'(MAX_DIGITS));
    assign tens_bad_s   = (sec_tens > 4'(SEC_TENS_MAX));

    // Entry/launch FSM with all outputs registered.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r     <= ST_IDLE;
            sec_units   <= 4'd0;
            sec_tens    <= 4'd0;
            min_units   <= 4'd0;
            min_tens    <= 4'd0;
            digit_count <= 3'd0;
            load        <= 1'b1;
            start       <= 1'b0;
            entry_error <= 1'b0;
            busy        <= 1'b0;
            running_q_r <= 1'b0;
        end else begin
            // Strobes are single-cycle: deasserted unless set below.
            load        <= 1'b1;
            start       <= 1'b0;
            running_q_r <= running;
            case (state_r)
                ST_IDLE, ST_ENTRY: begin
                    if (key_digit_s) begin
                        if (room_s) begin
                            min_tens    <= min_units;
                            min_units   <= sec_tens;
                            sec_tens    <= sec_units;
                            sec_units   <= key_code;
                            digit_count <= digit_count + 3'd1;
                            entry_error <= 1'b0;
                            state_r     <= ST_ENTRY;
                        end else begin
                            // Display full: extra digits are dropped.
                            state_r <= state_r;
                        end
                    end else if (key_cancel_s) begin
                        sec_units   <= 4'd0;
                        sec_tens    <= 4'd0;
                        min_units   <= 4'd0;
                        min_tens    <= 4'd0;
                        digit_count <= 3'd0;
                        entry_error <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (key_start_s) begin
                        // START with nothing entered (IDLE) is ignored.
                        if (state_r == ST_ENTRY) begin
                            if (tens_bad_s) begin
                                entry_error <= 1'b1;
                            end else begin
                                state_r <= ST_LOAD;
                                load    <= 1'b0;
                                busy    <= 1'b1;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    // Counters captured the digits on this edge; now launch.
                    start   <= 1'b1;
                    state_r <= ST_GO;
                end
                ST_GO: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    // Countdown finished when the chain enable falls.
                    if (running_q_r && !running) begin
                        sec_units   <= 4'd0;
                        sec_tens    <= 4'd0;
                        min_units   <= 4'd0;
                        min_tens    <= 4'd0;
                        digit_count <= 3'd0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle.
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// ---------------------------------------------------------------------------
// tb_time_entry_loader
//   Directed self-checking bench for time_entry_loader. Inputs change on the
//   falling clock edge; outputs are observed on the falling edge that follows
//   the causing rising edge.
// ---------------------------------------------------------------------------
module tb_time_entry_loader;

    logic       clk;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       running;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       load;
    logic       start;
    logic [2:0] digit_count;
    logic       entry_error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    time_entry_loader #(
        .SEC_TENS_MAX(5),
        .MAX_DIGITS  (4)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .running    (running),
        .sec_units  (sec_units),
        .sec_tens   (sec_tens),
        .min_units  (min_units),
        .min_tens   (min_tens),
        .load       (load),
        .start      (start),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed digit view {min_tens,min_units,sec_tens,sec_units}.
    function automatic logic [15:0] digits();
        return {min_tens, min_units, sec_tens, sec_units};
    endfunction

    // One-cycle key strobe; returns on the falling edge after the capturing
    // rising edge, which is the observation point for its effect.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        clear     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        running   = 1'b0;
        #12;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_count", 16'(digit_count), 16'd0);
        chk("rst_load", 16'(load), 16'd1);
        chk("rst_start", 16'(start), 16'd0);
        chk("rst_err", 16'(entry_error), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        clear = 1'b1;

        // Calculator-style shift of 1,3,0 -> 01:30
        press(4'd1);
        chk("shift1", digits(), 16'h0001);
        press(4'd3);
        press(4'd0);
        chk("130_digits", digits(), 16'h0130);
        chk("130_count", 16'(digit_count), 16'd3);
        chk("130_load", 16'(load), 16'd1);

        // Full display: fifth digit ignored
        press(4'hA);
        chk("cancel1_count", 16'(digit_count), 16'd0);
        press(4'd9);
        press(4'd9);
        press(4'd5);
        press(4'd9);
        press(4'd7);
        chk("full_digits", digits(), 16'h9959);
        chk("full_count", 16'(digit_count), 16'd4);

        // Invalid seconds tens -> rejected START
        press(4'hA);
        press(4'd1);
        press(4'd7);
        press(4'd0);
        press(4'hB);
        chk("rej_err", 16'(entry_error), 16'd1);
        chk("rej_load", 16'(load), 16'd1);
        chk("rej_busy", 16'(busy), 16'd0);
        chk("rej_digits", digits(), 16'h0170);
        chk("rej_count", 16'(digit_count), 16'd3);
        @(negedge clk);
        chk("rej_start", 16'(start), 16'd0);
        press(4'hA);
        chk("cancel2_digits", digits(), 16'h0000);
        chk("cancel2_count", 16'(digit_count), 16'd0);
        chk("cancel2_err", 16'(entry_error), 16'd0);

        // Valid entry 02:00, load / start / run sequence
        press(4'd2);
        press(4'd0);
        press(4'd0);
        press(4'hB);
        chk("ld_load", 16'(load), 16'd0);
        chk("ld_start", 16'(start), 16'd0);
        chk("ld_busy", 16'(busy), 16'd1);
        chk("ld_digits", digits(), 16'h0200);
        @(negedge clk);
        chk("go_start", 16'(start), 16'd1);
        chk("go_load", 16'(load), 16'd1);
        chk("go_busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("run_start", 16'(start), 16'd0);
        press(4'd5);
        chk("run_key_digits", digits(), 16'h0200);
        chk("run_key_count", 16'(digit_count), 16'd3);
        press(4'hA);
        chk("run_cancel_digits", digits(), 16'h0200);
        running = 1'b1;
        repeat (10) @(negedge clk);
        chk("running_busy", 16'(busy), 16'd1);
        running = 1'b0;
        @(negedge clk);
        chk("done_busy", 16'(busy), 16'd0);
        chk("done_digits", digits(), 16'h0000);
        chk("done_count", 16'(digit_count), 16'd0);

        // START with nothing entered
        press(4'hB);
        chk("empty_load", 16'(load), 16'd1);
        chk("empty_busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("empty_start", 16'(start), 16'd0);
        chk("empty_err", 16'(entry_error), 16'd0);

        // Undefined code changes nothing
        press(4'd3);
        press(4'hE);
        chk("undef_digits", digits(), 16'h0003);
        chk("undef_count", 16'(digit_count), 16'd1);
        chk("undef_err", 16'(entry_error), 16'd0);

        // Asynchronous reset while load is low
        press(4'hB);
        chk("pre_rst_load", 16'(load), 16'd0);
        #2;
        clear = 1'b0;
        #1;
        chk("arst_load", 16'(load), 16'd1);
        chk("arst_start", 16'(start), 16'd0);
        chk("arst_digits", digits(), 16'h0000);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_count", 16'(digit_count), 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_start", 16'(start), 16'd0);
        clear = 1'b1;

        // Back in IDLE: entry works again
        press(4'd6);
        chk("post_digits", digits(), 16'h0006);
        chk("post_count", 16'(digit_count), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
